// File: rtl/cpu8_pkg.sv
// Shared encodings for the 8-bit multi-cycle CPU: FSM states, opcodes,
// ALU operations and instruction field positions.
package cpu8_pkg;

    // FSM state encodings held by the datapath state register
    typedef enum logic [2:0] {
        StFetch     = 3'b000,
        StDecode    = 3'b001,
        StExecute   = 3'b010,
        StMemory    = 3'b011,
        StWriteback = 3'b100,
        StHalt      = 3'b101
    } state_e;

    // Instruction opcodes (instr[7:5])
    typedef enum logic [2:0] {
        OpLd   = 3'b000,
        OpSt   = 3'b001,
        OpAlu  = 3'b010,
        OpAddi = 3'b011,
        OpJmp  = 3'b100,
        OpJz   = 3'b101,
        OpNop  = 3'b110,
        OpHlt  = 3'b111
    } opcode_e;

    // ALU operation encodings
    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluXor  = 3'b100;
    localparam logic [2:0] AluNot  = 3'b101;
    localparam logic [2:0] AluShl  = 3'b110;
    localparam logic [2:0] AluPass = 3'b111;

    // Instruction field positions
    localparam int unsigned OpcodeMsb = 7;
    localparam int unsigned OpcodeLsb = 5;
    localparam int unsigned RegSelBit = 4;
    localparam int unsigned ImmMsb    = 3;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned ImmWidth  = ImmMsb - ImmLsb + 1;

    // One-hot opcode; field order puts each flag at the bit index of its opcode
    typedef struct packed {
        logic hlt;
        logic nop;
        logic jz;
        logic jmp;
        logic addi;
        logic alu;
        logic st;
        logic ld;
    } op_oh_t;

    // True for opcodes that visit the MEMORY state
    function automatic logic is_mem_op(input op_oh_t op);
        return op.ld | op.st;
    endfunction

endpackage

// File: rtl/cu_instr_decode.sv
// Instruction field splitter: one-hot opcode, register select and 4-bit
// immediate/offset/ALU-op field.
module cu_instr_decode
    import cpu8_pkg::*;
(
    input  logic [7:0]          instr_i,
    output op_oh_t              op_oh_o,
    output logic                r_o,
    output logic [ImmWidth-1:0] imm4_o
);

    logic [2:0] opcode;
    logic [7:0] onehot;

    assign opcode = instr_i[OpcodeMsb:OpcodeLsb];

    // Expand the 3-bit opcode into exactly one set flag
    always_comb begin
        onehot  = 8'd1 << opcode;
        op_oh_o = op_oh_t'(onehot);
    end

    assign r_o    = instr_i[RegSelBit];
    assign imm4_o = instr_i[ImmMsb:ImmLsb];

endmodule

// File: rtl/control_unit.sv
// Control unit of the 8-bit multi-cycle CPU. Decodes the instruction register
// and the externally held FSM state into next_state plus all datapath strobes.
// Decode is combinational; the only storage is the sticky halt flag.
// Optional build macro CU_ILLEGAL_TRAP_EN: illegal state codes 110/111 trap
// into HALT_STATE instead of falling back to FETCH.
module control_unit
    import cpu8_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic [2:0] state,
    input  logic       zf,
    output logic [2:0] next_state,
    output logic       pc_we,
    output logic       pc_sel,
    output logic [3:0] pc_offset,
    output logic       addr_sel,
    output logic [3:0] addr_offset,
    output logic       mem_sel,
    output logic       mem_we,
    output logic [2:0] alu_opcode,
    output logic       alu_sel_a,
    output logic       alu_sel_b,
    output logic       alu_we,
    output logic       zf_we,
    output logic       ir_we,
    output logic       a_sel,
    output logic       b_sel,
    output logic       a_we,
    output logic       b_we,
    output logic       halt
);

    op_oh_t     op;
    logic       r;
    logic [3:0] imm4;
    state_e     cur_state;
    state_e     ns;
    logic       halt_c;
    logic       halt_d;
    logic       halt_q;

    cu_instr_decode u_instr_decode (
        .instr_i (instr),
        .op_oh_o (op),
        .r_o     (r),
        .imm4_o  (imm4)
    );

    assign cur_state = state_e'(state);

    // State/opcode decode; reset overrides everything back to defaults
    always_comb begin
        ns          = StFetch;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        pc_offset   = 4'd0;
        addr_sel    = 1'b0;
        addr_offset = 4'd0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        alu_opcode  = AluAdd;
        alu_sel_a   = 1'b0;
        alu_sel_b   = 1'b0;
        alu_we      = 1'b0;
        zf_we       = 1'b0;
        ir_we       = 1'b0;
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        a_we        = 1'b0;
        b_we        = 1'b0;
        halt_c      = 1'b0;

        if (!reset) begin
            case (cur_state)
                StFetch: begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    pc_sel   = 1'b0;
                    addr_sel = 1'b0;
                    ns       = StDecode;
                end

                StDecode: begin
                    if (op.hlt) begin
                        ns = StHalt;
                    end else if (op.nop) begin
                        ns = StFetch;
                    end else if (is_mem_op(op)) begin
                        ns = StMemory;
                    end else begin
                        ns = StExecute;
                    end
                end

                StExecute: begin
                    unique case (1'b1)
                        op.alu: begin
                            alu_opcode = imm4[2:0];
                            alu_sel_a  = 1'b0;
                            alu_sel_b  = 1'b0;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            ns         = StWriteback;
                        end
                        op.addi: begin
                            alu_opcode = AluAdd;
                            alu_sel_a  = r;
                            alu_sel_b  = 1'b1;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            ns         = StWriteback;
                        end
                        op.jmp, op.jz: begin
                            // A not-taken JZ leaves every strobe idle
                            if (op.jmp || zf) begin
                                pc_we     = 1'b1;
                                pc_sel    = 1'b1;
                                pc_offset = imm4;
                            end
                            ns = StFetch;
                        end
                        default: ;
                    endcase
                end

                StMemory: begin
                    if (is_mem_op(op)) begin
                        addr_sel    = 1'b1;
                        addr_offset = imm4;
                        if (op.ld) begin
                            ns = StWriteback;
                        end else begin
                            mem_we  = 1'b1;
                            mem_sel = r;
                            ns      = StFetch;
                        end
                    end
                end

                StWriteback: begin
                    if (op.ld || op.alu || op.addi) begin
                        a_we = ~r;
                        b_we = r;
                        // Loads keep the data address on the bus while memory data is written
                        if (op.ld) begin
                            addr_sel    = 1'b1;
                            addr_offset = imm4;
                            a_sel       = ~r;
                            b_sel       = r;
                        end
                        ns = StFetch;
                    end
                end

                StHalt: begin
                    halt_c = 1'b1;
                    ns     = StHalt;
                end

                default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    halt_c = 1'b1;
                    ns     = StHalt;
`else
                    ns     = StFetch;
`endif
                end
            endcase
        end
    end

    assign next_state = ns;

    // Halt flag accumulates any cycle in which halt was decoded
    always_comb begin
        halt_d = halt_q | halt_c;
    end

    // Sticky halt flag, cleared only by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Reported halt masks the flag while reset is asserted
    assign halt = ~reset & (halt_c | halt_q);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// vectors compared against a rule-level model of the control decode.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic [2:0] state;
    logic       zf;
    logic [2:0] next_state;
    logic       pc_we, pc_sel, addr_sel, mem_sel, mem_we;
    logic [3:0] pc_offset, addr_offset;
    logic [2:0] alu_opcode;
    logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
    logic       a_sel, b_sel, a_we, b_we, halt;

    typedef struct packed {
        logic [2:0] next_state;
        logic       pc_we;
        logic       pc_sel;
        logic [3:0] pc_offset;
        logic       addr_sel;
        logic [3:0] addr_offset;
        logic       mem_sel;
        logic       mem_we;
        logic [2:0] alu_opcode;
        logic       alu_sel_a;
        logic       alu_sel_b;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_sel;
        logic       b_sel;
        logic       a_we;
        logic       b_we;
        logic       halt;
    } outs_t;

    outs_t act;
    outs_t exp;
    logic  model_flag;
    int    errors;
    int    checks;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .state       (state),
        .zf          (zf),
        .next_state  (next_state),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .pc_offset   (pc_offset),
        .addr_sel    (addr_sel),
        .addr_offset (addr_offset),
        .mem_sel     (mem_sel),
        .mem_we      (mem_we),
        .alu_opcode  (alu_opcode),
        .alu_sel_a   (alu_sel_a),
        .alu_sel_b   (alu_sel_b),
        .alu_we      (alu_we),
        .zf_we       (zf_we),
        .ir_we       (ir_we),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .a_we        (a_we),
        .b_we        (b_we),
        .halt        (halt)
    );

    assign act = {next_state, pc_we, pc_sel, pc_offset, addr_sel, addr_offset, mem_sel, mem_we,
                  alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we, a_sel, b_sel, a_we,
                  b_we, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the instruction-set rules, given the sticky flag
    function automatic outs_t model(input logic rst, input logic [7:0] ins, input logic [2:0] st,
                                    input logic z, input logic flag);
        outs_t      o;
        logic [2:0] op;
        logic       rr;
        logic [3:0] lo;
        logic       hc;
        o  = '0;
        hc = 1'b0;
        op = ins[7:5];
        rr = ins[4];
        lo = ins[3:0];
        if (!rst) begin
            case (st)
                3'd0: begin
                    o.ir_we = 1'b1;
                    o.pc_we = 1'b1;
                    o.next_state = 3'd1;
                end
                3'd1: o.next_state = (op == 3'd7) ? 3'd5 : (op == 3'd6) ? 3'd0 :
                                     (op <= 3'd1) ? 3'd3 : 3'd2;
                3'd2: begin
                    if (op == 3'd2) begin
                        o.alu_opcode = lo[2:0];
                        o.alu_we = 1'b1;
                        o.zf_we = 1'b1;
                        o.next_state = 3'd4;
                    end else if (op == 3'd3) begin
                        o.alu_sel_a = rr;
                        o.alu_sel_b = 1'b1;
                        o.alu_we = 1'b1;
                        o.zf_we = 1'b1;
                        o.next_state = 3'd4;
                    end else if (op == 3'd4 || (op == 3'd5 && z)) begin
                        o.pc_we = 1'b1;
                        o.pc_sel = 1'b1;
                        o.pc_offset = lo;
                    end
                end
                3'd3: begin
                    if (op <= 3'd1) begin
                        o.addr_sel = 1'b1;
                        o.addr_offset = lo;
                        if (op == 3'd0) begin
                            o.next_state = 3'd4;
                        end else begin
                            o.mem_we = 1'b1;
                            o.mem_sel = rr;
                        end
                    end
                end
                3'd4: begin
                    if (op == 3'd0 || op == 3'd2 || op == 3'd3) begin
                        o.a_we = !rr;
                        o.b_we = rr;
                        if (op == 3'd0) begin
                            o.addr_sel = 1'b1;
                            o.addr_offset = lo;
                            o.a_sel = !rr;
                            o.b_sel = rr;
                        end
                    end
                end
                3'd5: begin
                    hc = 1'b1;
                    o.next_state = 3'd5;
                end
                default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    hc = 1'b1;
                    o.next_state = 3'd5;
`endif
                end
            endcase
            o.halt = hc | flag;
        end
        return o;
    endfunction

    task automatic drive(input logic r, input logic [7:0] i, input logic [2:0] s, input logic z);
        @(negedge clk);
        reset = r;
        instr = i;
        state = s;
        zf    = z;
        #1;
    endtask

    // Advance one clock and track the sticky flag in the model
    task automatic tick();
        @(posedge clk);
        model_flag = reset ? 1'b0 : model(reset, instr, state, zf, model_flag).halt;
    endtask

    task automatic test_reset();
        logic [7:0] ins_tab [6];
        ins_tab = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0};
        for (int s = 0; s < 6; s++) begin
            drive(1'b1, ins_tab[s], 3'(s), 1'(s & 1));
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_defaults st=%0d: got %h expected 0", s, act);
            end
            tick();
        end
        model_flag = 1'b0;
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'($urandom), 3'd0, 1'($urandom));
            exp = model(reset, instr, state, zf, model_flag);
            checks++;
            if (act !== exp || next_state !== 3'd1 || ir_we !== 1'b1) begin
                errors++;
                $display("FAIL fetch instr=%h: got %h expected %h", instr, act, exp);
            end
            tick();
        end
    endtask

    task automatic test_jz();
        drive(1'b0, 8'hA5, 3'd2, 1'b1);
        checks++;
        if (pc_we !== 1'b1 || pc_sel !== 1'b1 || pc_offset !== 4'b0101 || next_state !== 3'd0) begin
            errors++;
            $display("FAIL jz_taken: got pc_we=%b pc_sel=%b off=%b ns=%0d expected 1 1 0101 0",
                     pc_we, pc_sel, pc_offset, next_state);
        end
        tick();
        drive(1'b0, 8'hA5, 3'd2, 1'b0);
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL jz_not_taken: got %h expected 0", act);
        end
        tick();
    endtask

    task automatic test_ld_b();
        drive(1'b0, 8'h13, 3'd3, 1'b0);
        checks++;
        if (addr_sel !== 1'b1 || addr_offset !== 4'b0011 || next_state !== 3'd4 || mem_we !== 1'b0)
        begin
            errors++;
            $display("FAIL ld_memory: got sel=%b off=%b ns=%0d we=%b expected 1 0011 4 0",
                     addr_sel, addr_offset, next_state, mem_we);
        end
        tick();
        drive(1'b0, 8'h13, 3'd4, 1'b0);
        exp = model(reset, instr, state, zf, model_flag);
        checks++;
        if (act !== exp || b_we !== 1'b1 || b_sel !== 1'b1 || a_we !== 1'b0) begin
            errors++;
            $display("FAIL ld_writeback: got %h expected %h", act, exp);
        end
        tick();
    endtask

    task automatic test_alu();
        drive(1'b0, 8'h52, 3'd2, 1'b0);
        checks++;
        if (alu_opcode !== 3'b010 || alu_we !== 1'b1 || zf_we !== 1'b1 || next_state !== 3'd4)
        begin
            errors++;
            $display("FAIL alu_execute: got op=%b we=%b zwe=%b ns=%0d expected 010 1 1 4",
                     alu_opcode, alu_we, zf_we, next_state);
        end
        tick();
        drive(1'b0, 8'h52, 3'd4, 1'b0);
        checks++;
        if (b_we !== 1'b1 || b_sel !== 1'b0 || a_we !== 1'b0 || next_state !== 3'd0) begin
            errors++;
            $display("FAIL alu_writeback: got b_we=%b b_sel=%b a_we=%b expected 1 0 0",
                     b_we, b_sel, a_we);
        end
        tick();
    endtask

    task automatic test_halt();
        drive(1'b0, 8'hE0, 3'd1, 1'b0);
        checks++;
        if (next_state !== 3'd5 || halt !== 1'b0) begin
            errors++;
            $display("FAIL hlt_decode: got ns=%0d halt=%b expected 5 0", next_state, halt);
        end
        tick();
        drive(1'b0, 8'hE0, 3'd5, 1'b0);
        checks++;
        if (halt !== 1'b1 || next_state !== 3'd5) begin
            errors++;
            $display("FAIL hlt_state: got halt=%b ns=%0d expected 1 5", halt, next_state);
        end
        tick();
        drive(1'b0, 8'hE0, 3'd0, 1'b0);
        checks++;
        if (halt !== 1'b1 || next_state !== 3'd1) begin
            errors++;
            $display("FAIL hlt_sticky: got halt=%b ns=%0d expected 1 1", halt, next_state);
        end
        // Asynchronous reset pulse between clock edges
        reset = 1'b1;
        #1;
        checks++;
        if (halt !== 1'b0 || act !== '0) begin
            errors++;
            $display("FAIL hlt_async_reset: got %h expected 0", act);
        end
        reset = 1'b0;
        model_flag = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL hlt_flag_cleared: got halt=%b expected 0", halt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 7) == 0), 8'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom));
            exp = model(reset, instr, state, zf, model_flag);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random rst=%b instr=%h st=%0d zf=%b: got %h expected %h",
                         reset, instr, state, zf, act, exp);
            end
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_flag = 1'b0;
        reset = 1'b1;
        instr = 8'h00;
        state = 3'd0;
        zf = 1'b0;
        test_reset();
        test_fetch();
        test_jz();
        test_ld_b();
        test_alu();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Control unit of the 8-bit multi-cycle CPU.
- Decodes the instruction register (instr) and the FSM state held by the datapath state register. Produces next_state and all datapath strobes and selects.
- Output decode is combinational. The only storage is a sticky halt flag.
- Reset forces every output to its inactive default.

Parameters:
- none. Encodings are fixed constants from the shared package.

Ports:
- clk  in  1  system clock; clocks only the sticky halt flag
- reset  in  1  asynchronous, active-high reset
- instr  in  8  instruction: [7:5] opcode, [4] r (0=A, 1=B), [3:0] off/imm/aluop
- state  in  3  current FSM state
- zf  in  1  zero flag
- next_state  out  3  state to load on next clk
- pc_we  out  1  PC write enable
- pc_sel  out  1  0 = PC+1, 1 = PC+pc_offset
- pc_offset  out  4  relative branch offset (raw instr[3:0])
- addr_sel  out  1  memory address source: 0 = PC, 1 = data base+addr_offset
- addr_offset  out  4  data address offset
- mem_sel  out  1  store data source: 0 = A, 1 = B
- mem_we  out  1  memory write enable
- alu_opcode  out  3  ALU operation
- alu_sel_a  out  1  ALU A input: 0 = reg A, 1 = reg B
- alu_sel_b  out  1  ALU B input: 0 = reg B, 1 = zero-extended imm4
- alu_we  out  1  ALU result register write enable
- zf_we  out  1  zero-flag write enable
- ir_we  out  1  instruction register write enable
- a_sel / b_sel  out  1  register write source: 0 = ALU result, 1 = memory data
- a_we / b_we  out  1  register write enables
- halt  out  1  CPU halted

Behaviour:

States:
- FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101.

Opcodes:
- 000 LD, 001 ST, 010 ALU, 011 ADDI, 100 JMP, 101 JZ, 110 NOP, 111 HLT.

Defaults:
- Every output is 0, and next_state is FETCH, unless a rule below drives it.

Reset:
- While reset=1, all outputs hold their defaults regardless of instr, state or zf. next_state=FETCH and halt=0.
- The override is purely combinational, so it acts with no clock.
- reset asynchronously clears the halt flag.

FETCH:
- ir_we=1, pc_we=1, pc_sel=0, addr_sel=0.
- next_state: DECODE.

DECODE:
- No strobes.
- next_state: HLT -> HALT_STATE; NOP -> FETCH; LD/ST -> MEMORY; all others -> EXECUTE.

EXECUTE:
- ALU:
  - alu_opcode=instr[2:0], alu_sel_a=0, alu_sel_b=0, alu_we=1, zf_we=1.
  - next_state: WRITEBACK.
- ADDI:
  - alu_opcode=000 (add), alu_sel_a=r, alu_sel_b=1, alu_we=1, zf_we=1.
  - next_state: WRITEBACK.
- JMP:
  - pc_we=1, pc_sel=1, pc_offset=instr[3:0].
  - next_state: FETCH.
- JZ:
  - Same outputs as JMP, gated by zf. With zf=0 all outputs stay at defaults.
  - next_state: FETCH.

MEMORY:
- All memory opcodes: addr_sel=1, addr_offset=instr[3:0].
- LD: next_state WRITEBACK.
- ST: mem_we=1, mem_sel=r; next_state FETCH.

WRITEBACK:
- Write enable: a_we=~r, b_we=r.
- LD:
  - addr_sel=1 and addr_offset stay held.
  - The selected a_sel/b_sel=1.
- ALU/ADDI: a_sel/b_sel=0.
- next_state: FETCH.

HALT_STATE:
- halt=1, next_state=HALT_STATE.
- Only reset exits this state.

Sticky halt flag:
- Set on the clk rising edge whenever halt is asserted.
- halt output = combinational halt OR flag, except during reset.

Illegal inputs:
- Opcode/state combinations not listed drive all outputs to defaults with next_state=FETCH.
- Illegal state codes 110 and 111 are handled likewise, except as modified by the optional feature.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: state codes 110/111 give next_state=HALT_STATE and halt=1, which sets the flag.
- Undefined: state codes 110/111 give defaults with next_state=FETCH.

Decomposition:
- Package cpu8_pkg holds:
  - state encodings
  - opcode encodings
  - ALU opcode encodings (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 PASS)
  - instruction field positions
- One sub-module, cu_instr_decode: splits instr into a one-hot opcode, r and imm4.
- The FSM/output logic and the halt register stay in control_unit.

Test Plan:
- reset=1; sweep state 000..101, instr 00,20,40,60,80,A0, zf alternating -> all outputs 0, next_state=000 every time.
- reset=0, state=FETCH, any instr -> ir_we=1, pc_we=1, pc_sel=0, next_state=DECODE; all else 0.
- state=EXECUTE, instr=8'hA5:
  - zf=1 -> pc_we=1, pc_sel=1, pc_offset=0101, next_state=FETCH.
  - zf=0 -> pc_we=0.
- LD B, instr=8'h13:
  - MEMORY -> addr_sel=1, addr_offset=0011, next_state=WRITEBACK.
  - WRITEBACK -> b_we=1, b_sel=1, a_we=0.
- instr=8'h52 at EXECUTE -> alu_opcode=010, alu_we=1, zf_we=1, next_state=WRITEBACK; then WRITEBACK -> b_we=1, b_sel=0.
- HLT (8'hE0):
  - DECODE -> next_state=HALT_STATE.
  - HALT_STATE -> halt=1.
  - After a clk edge, halt stays 1 even with state=FETCH.
  - Async reset pulse -> halt=0 immediately.
